uart_rx_frame: RTL and testbench

Asynchronous 8N1 serial receiver clocked from the 50 MHz system clock and paced by the 16x-oversampled receive enable from the baud rate generator. Synchronises the `rx` pin, validates the start bit, samples each data bit at mid-bit, checks the stop bit and presents the byte with a ready flag until the consumer clears it. It sits between the baud rate generator and the byte consumer (loopback/transmit path or user logic).

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_frame_if.sv | 13 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_frame.sv | 99 +++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and frame constants
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_OSR       = 16;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MID_TICK  = 8;
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: receive line, oversample enable and byte/flag handoff to the consumer
interface uart_rx_frame_if;
  import uart_pkg::*;
  logic                      rxclk_en;
  logic                      rx;
  logic                      rdy_clr;
  logic [UART_DATA_BITS-1:0] data;
  logic                      rdy;
  logic                      frame_err;
  logic                      overrun;
  modport master (output rxclk_en, rx, rdy_clr, input data, rdy, frame_err, overrun);
  modport slave  (input rxclk_en, rx, rdy_clr, output data, rdy, frame_err, overrun);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop rx synchroniser and per-tick decision bit rx_d.
// Defining UART_RX_MAJORITY_EN replaces the direct capture with a 3-sample majority vote.
module uart_rx_sync (
  input  logic clk_50m,
  input  logic rst,
  input  logic rxclk_en,
  input  logic rx,
  output logic rx_d
);
  logic [1:0] sync;
  logic       rx_s;
  always_ff @(posedge clk_50m)
    sync <= rst ? 2'b11 : {sync[0], rx};
  assign rx_s = sync[1];
`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist;
  always_ff @(posedge clk_50m)
    if (rst) hist <= 3'b111;
    else if (rxclk_en) hist <= {hist[1:0], rx_s};
  assign rx_d = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
`else
  always_ff @(posedge clk_50m)
    if (rst) rx_d <= 1'b1;
    else if (rxclk_en) rx_d <= rx_s;
`endif
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver FSM with ready, frame-error and overrun flags.
// Build option UART_RX_MAJORITY_EN enables the majority line filter in uart_rx_sync.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OSR       = UART_OSR
) (
  input logic            clk_50m,
  input logic            rst,
  uart_rx_frame_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;
  logic [1:0]           state;
  logic [3:0]           tcnt;
  logic [2:0]           bidx;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] data;
  logic                 rx_d;
  logic                 armed;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 last_tick;
  logic                 stop_mid;
  uart_rx_sync u_sync (
    .clk_50m,
    .rst,
    .rxclk_en (bus.rxclk_en),
    .rx       (bus.rx),
    .rx_d
  );
  assign last_tick = tcnt == 4'(OSR - 1);
  assign stop_mid  = bus.rxclk_en && state == ST_STOP && last_tick;
  // armed must see the line high before a falling edge counts, so a held break cannot retrigger
  always_ff @(posedge clk_50m)
    if (rst) begin
      state <= ST_IDLE;
      armed <= 1'b0;
      tcnt  <= '0;
      bidx  <= '0;
      sh    <= '0;
    end else if (bus.rxclk_en) begin
      case (state)
        ST_IDLE:
          if (armed && !rx_d) begin
            state <= ST_START;
            tcnt  <= 4'd1;
            armed <= 1'b0;
          end else if (rx_d) armed <= 1'b1;
        ST_START:
          if (rx_d) state <= ST_IDLE;
          else if (tcnt == 4'(UART_MID_TICK - 1)) begin
            state <= ST_DATA;
            tcnt  <= '0;
            bidx  <= '0;
          end else tcnt <= tcnt + 4'd1;
        ST_DATA:
          if (last_tick) begin
            sh   <= {rx_d, sh[DATA_BITS-1:1]};
            tcnt <= '0;
            if (bidx == 3'(DATA_BITS - 1)) state <= ST_STOP;
            else bidx <= bidx + 3'd1;
          end else tcnt <= tcnt + 4'd1;
        default:
          if (last_tick) begin
            state <= ST_IDLE;
            tcnt  <= '0;
          end else tcnt <= tcnt + 4'd1;
      endcase
    end
  // a new byte takes priority over a same-cycle rdy_clr; overrun tracks rdy from before the edge
  always_ff @(posedge clk_50m)
    if (rst) begin
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bus.rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (stop_mid && rx_d) begin
        data      <= sh;
        rdy       <= 1'b1;
        frame_err <= 1'b0;
        if (rdy) overrun <= 1'b1;
      end
      if (stop_mid && !rx_d) frame_err <= 1'b1;
    end
  assign bus.data      = data;
  assign bus.rdy       = rdy;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and random 8N1 frames checked against a byte-level receiver model
module tb_uart_rx_frame;
  localparam int DIV   = 8;
  localparam int CLK_P = 20;
`ifdef UART_RX_MAJORITY_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif
  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       clr_man = 1'b0;
  logic       clr_tick = 1'b0;
  logic       rdy_q = 1'b0;
  logic       ferr_q = 1'b0;
  int         div_cnt = 0;
  int         tick_n = 0;
  int         clr_at = -1;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ferr_rises = 0;
  time        t_start = 0;
  time        t_rise = 0;
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_ovr;
  uart_rx_frame_if bus ();
  uart_rx_frame dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .bus     (bus)
  );
  assign bus.rdy_clr = clr_man | clr_tick;
  always #(CLK_P / 2) clk_50m = ~clk_50m;
  // rxclk_en every DIV clocks (compressed baud); also watches rdy and frame_err edges
  always @(negedge clk_50m) begin
    div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
    bus.rxclk_en = div_cnt == 0;
    if (bus.rxclk_en) tick_n++;
    clr_tick = bus.rxclk_en && tick_n == clr_at;
    if (bus.rdy && !rdy_q) t_rise = $time;
    if (bus.frame_err && !ferr_q) ferr_rises++;
    rdy_q = bus.rdy;
    ferr_q = bus.frame_err;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic void m_reset();
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endfunction
  function automatic void m_clr();
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endfunction
  function automatic void m_frame(input logic [7:0] b, input logic ok);
    if (ok) begin
      m_ovr = m_ovr | m_rdy;
      m_data = b;
      m_rdy = 1'b1;
      m_ferr = 1'b0;
    end else m_ferr = 1'b1;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(bus.data), 32'(m_data));
    chk({tag, ".rdy"}, 32'(bus.rdy), 32'(m_rdy));
    chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
  endtask
  task automatic wait_tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      while (!bus.rxclk_en) @(posedge clk_50m);
    end
  endtask
  task automatic clr_pulse();
    @(negedge clk_50m) clr_man = 1'b1;
    @(negedge clk_50m) clr_man = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk_50m) rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
  endtask
  // one frame on tick boundaries; optional 1-tick low spike mid data bit and rdy_clr at a tick offset
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int spike_bit = -1,
                            input int clr_off = -1);
    int s;
    int rem;
    wait_tick(4);
    s = tick_n;
    if (clr_off >= 0) clr_at = s + clr_off;
    @(negedge clk_50m);
    bus.rx = 1'b0;
    t_start = $time;
    rem = 16;
    for (int k = 0; k <= 8; k++) begin
      wait_tick(rem);
      @(negedge clk_50m);
      bus.rx = (k < 8) ? b[k] : stop_ok;
      rem = 16;
      if (k == spike_bit) begin
        wait_tick(7);
        @(negedge clk_50m) bus.rx = 1'b0;
        wait_tick(1);
        @(negedge clk_50m) bus.rx = b[k];
        rem = 8;
      end
    end
    wait_tick(rem);
    @(negedge clk_50m);
    bus.rx = 1'b1;
    clr_at = -1;
  endtask
  initial begin
    logic [7:0] b;
    logic       ok;
    logic       old;
    int         n0;
    longint     lat;
    bus.rx = 1'b1;
    m_reset();
    repeat (4) @(negedge clk_50m);
    rst = 1'b0;
    check_all("reset");
    send_frame(8'hA5, 1'b1);
    m_frame(8'hA5, 1'b1);
    check_all("a5");
    lat = longint'(t_rise) - longint'(t_start);
    chk("a5.latency", 32'(lat >= (152 + M - 1) * DIV * CLK_P - 3 * CLK_P &&
                          lat <= (152 + M + 1) * DIV * CLK_P + 3 * CLK_P), 32'd1);
    clr_pulse();
    m_clr();
    check_all("a5.clr");
    send_frame(8'h3C, 1'b1);
    m_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    m_frame(8'hC3, 1'b1);
    check_all("overrun");
    clr_pulse();
    m_clr();
    send_frame(8'h11, 1'b1);
    m_frame(8'h11, 1'b1);
    check_all("pre_set_clr");
    old = m_rdy;
    send_frame(8'h5A, 1'b1, -1, 153 + M);
    m_clr();
    m_frame(8'h5A, 1'b1);
    m_ovr = old;
    check_all("set_wins");
    do_reset();
    m_reset();
    check_all("rst");
    send_frame(8'h55, 1'b0);
    m_frame(8'h55, 1'b0);
    check_all("bad_stop");
    do_reset();
    m_reset();
    n0 = ferr_rises;
    wait_tick(2);
    @(negedge clk_50m) bus.rx = 1'b0;
    wait_tick(480);
    @(negedge clk_50m) bus.rx = 1'b1;
    m_frame(8'h00, 1'b0);
    chk("break.events", 32'(ferr_rises - n0), 32'd1);
    check_all("break");
    send_frame(8'h0F, 1'b1);
    m_frame(8'h0F, 1'b1);
    check_all("after_break");
    clr_pulse();
    m_clr();
    wait_tick(4);
    @(negedge clk_50m) bus.rx = 1'b0;
    wait_tick(4);
    @(negedge clk_50m) bus.rx = 1'b1;
    wait_tick(200);
    check_all("glitch");
    send_frame(8'h81, 1'b1);
    m_frame(8'h81, 1'b1);
    check_all("after_glitch");
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_tick(4 + 88);
        @(negedge clk_50m) rst = 1'b1;
        @(negedge clk_50m) rst = 1'b0;
      end
    join
    m_reset();
    check_all("rst_mid");
    send_frame(8'h12, 1'b1);
    m_frame(8'h12, 1'b1);
    check_all("after_rst");
    send_frame(8'hFF, 1'b1, 2);
    m_frame((M != 0) ? 8'hFF : 8'hFB, 1'b1);
    check_all("spike");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      ok = $urandom_range(0, 3) != 0;
      send_frame(b, ok);
      m_frame(b, ok);
      check_all("rnd");
      if ($urandom_range(0, 1) == 1) begin
        clr_pulse();
        m_clr();
        chk("rnd.clr", 32'(bus.rdy), 32'(m_rdy));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
